// File: rtl/can_mac_pkg.sv
// Shared types, constants and the CRC-15 step function for the CAN MAC.
package can_mac_pkg;

  localparam int CAN_CRC_W = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CRC_FIELD,
    DONE
  } crc_state_t;

  // One bit-serial step: feedback is the incoming bit XOR the current MSB.
  function automatic logic [CAN_CRC_W-1:0] crc15_next(input logic [CAN_CRC_W-1:0] crc,
                                                      input logic b);
    logic inv;
    inv = b ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (inv ? CAN_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_crc15_lfsr.sv
// CAN CRC-15 shift register with synchronous clear and clock enable.
module can_crc15_lfsr
  import can_mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [CAN_CRC_W-1:0] crc,
  output logic [CAN_CRC_W-1:0] crc_next
);

  assign crc_next = crc15_next(crc, bit_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/can_mac_crc_seq.sv
// Per-frame CRC-15 sequencer: accumulate covered bits, snapshot, then
// serialise (TX) or check (RX) the 15-bit CRC field MSB first.
module can_mac_crc_seq
  import can_mac_pkg::*;
#(
  parameter int CRC_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             tx_mode,
  input  logic             bit_strb,
  input  logic             bit_val,
  input  logic             field_end,
  input  logic             abort,
  output logic             tx_crc_bit,
  output logic             tx_crc_valid,
  output logic [CRC_W-1:0] crc_val,
  output logic             crc_done,
  output logic             crc_err,
  output logic             busy
);

  crc_state_t           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [CAN_CRC_W-1:0] snap_q, snap_d;
  logic                 err_q, err_d;
  logic                 tx_q, tx_d;
  logic                 lfsr_clr, lfsr_en;
  logic [CAN_CRC_W-1:0] lfsr_crc, lfsr_next;

  can_crc15_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .clr     (lfsr_clr),
    .en      (lfsr_en),
    .bit_in  (bit_val),
    .crc     (lfsr_crc),
    .crc_next(lfsr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      err_q   <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    err_d    = err_q;
    tx_d     = tx_q;
    lfsr_clr = 1'b0;
    lfsr_en  = 1'b0;
    if (frame_start) begin
      state_d  = ACCUM;
      err_d    = 1'b0;
      tx_d     = tx_mode;
      lfsr_clr = 1'b1;
    end else if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bit_strb) begin
            lfsr_en = 1'b1;
            // The closing bit is folded in, so capture the LFSR's next value.
            if (field_end) begin
              snap_d  = lfsr_next;
              cnt_d   = 4'd14;
              state_d = CRC_FIELD;
            end
          end
        end
        CRC_FIELD: begin
          if (bit_strb) begin
            if (!tx_q && (bit_val != snap_q[cnt_q])) err_d = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  assign tx_crc_valid = (state_q == CRC_FIELD) && tx_q;
  assign tx_crc_bit   = tx_crc_valid && snap_q[cnt_q];
  assign crc_val      = snap_q;
  assign crc_done     = (state_q == DONE);
  assign crc_err      = err_q;
  assign busy         = (state_q == ACCUM) || (state_q == CRC_FIELD);

endmodule

// File: tb/tb_can_mac_crc_seq.sv
// Randomised scoreboard bench for the CAN CRC-15 sequencer.
module tb_can_mac_crc_seq;

  typedef struct {
    logic [14:0] crc;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, tx_mode, bit_strb, bit_val, field_end, abort;
  logic        tx_crc_bit, tx_crc_valid, crc_done, crc_err, busy;
  logic [14:0] crc_val;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  logic exp_bits_q[$];
  bit   msg[$];

  can_mac_crc_seq #(.CRC_W(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .tx_mode     (tx_mode),
    .bit_strb    (bit_strb),
    .bit_val     (bit_val),
    .field_end   (field_end),
    .abort       (abort),
    .tx_crc_bit  (tx_crc_bit),
    .tx_crc_valid(tx_crc_valid),
    .crc_val     (crc_val),
    .crc_done    (crc_done),
    .crc_err     (crc_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Remainder of msg(x) * x^15 divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
  function automatic logic [14:0] ref_crc();
    bit          a[$];
    logic [15:0] g;
    logic [14:0] r;
    int          n;
    g = 16'hC599;
    a = msg;
    n = msg.size();
    for (int i = 0; i < 15; i++) a.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 16; j++) a[i+j] = a[i+j] ^ g[15-j];
    r = '0;
    for (int k = 0; k < 15; k++) r = {r[13:0], a[n+k]};
    return r;
  endfunction

  task automatic cyc(input logic fs, input logic tm, input logic st,
                     input logic bv, input logic fe, input logic ab);
    frame_start = fs; tx_mode = tm; bit_strb = st; bit_val = bv; field_end = fe; abort = ab;
    @(posedge clk);
    #1;
    frame_start = 0; tx_mode = 0; bit_strb = 0; bit_val = 0; field_end = 0; abort = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // abort_at >= 0 aborts the frame after that many CRC-field strobes.
  task automatic run_frame(input bit tx, input int errpos, input int abort_at);
    logic [14:0] e;
    logic        b;
    int          n;
    exp_t        ent;
    e = ref_crc();
    n = msg.size();
    cyc(1, tx, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      cyc(0, 0, 1, msg[i], i == n - 1, 0);
    end
    chk("snapshot", crc_val, e);
    if (tx) for (int k = 14; k >= 0; k--) exp_bits_q.push_back(e[k]);
    for (int k = 14; k >= 0; k--) begin
      if (abort_at >= 0 && (14 - k) == abort_at) begin
        cyc(0, 0, 0, 0, 0, 1);
        exp_bits_q.delete();
        return;
      end
      repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 0, 0);
      chk("tx_valid", tx_crc_valid, tx);
      b = tx ? 1'($urandom_range(0, 1)) : e[k];
      if (!tx && k == errpos) b = ~b;
      cyc(0, 0, 1, b, 1'($urandom_range(0, 1)), 0);
    end
    ent.crc = e;
    ent.err = !tx && (errpos >= 0);
    sb_q.push_back(ent);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (crc_done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          exp_t ent;
          ent = sb_q.pop_front();
          chk("done_crc", crc_val, ent.crc);
          chk("done_err", crc_err, ent.err);
        end
      end
      if (bit_strb && tx_crc_valid) begin
        if (exp_bits_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_bit actual=1 expected=0");
        end else begin
          chk("tx_bit", tx_crc_bit, exp_bits_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    logic [14:0] held;
    rst = 1; frame_start = 0; tx_mode = 0; bit_strb = 0; bit_val = 0; field_end = 0; abort = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_crc_val", crc_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", crc_done, 0);
    chk("rst_err", crc_err, 0);
    chk("rst_tx_valid", tx_crc_valid, 0);
    chk("rst_tx_bit", tx_crc_bit, 0);

    msg = '{1};
    run_frame(0, -1, -1);
    chk("rx_one_crc", crc_val, 15'h4599);
    idle(2);
    chk("rx_one_err", crc_err, 0);

    msg = '{1};
    run_frame(0, 7, -1);
    idle(3);
    chk("err_held", crc_err, 1);
    chk("err_idle_busy", busy, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("err_cleared", crc_err, 0);
    cyc(0, 0, 0, 0, 0, 1);

    msg = '{1, 0};
    run_frame(1, -1, -1);
    chk("tx_crc", crc_val, 15'h4EAB);
    idle(2);

    msg.delete();
    repeat (12) msg.push_back(1'($urandom_range(0, 1)));
    held = ref_crc();
    d0 = done_cnt;
    run_frame(0, -1, 5);
    chk("abort_busy", busy, 0);
    idle(4);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_held", crc_val, held);
    msg = '{0};
    run_frame(0, -1, -1);
    chk("zero_crc", crc_val, 0);
    idle(2);

    repeat (3) cyc(0, 0, 1, 1, 1, 0);
    chk("idle_strb_crc", crc_val, 0);
    chk("idle_strb_busy", busy, 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("fs_beats_abort", busy, 1);
    cyc(0, 0, 1, 1, 1, 0);
    chk("fs_abort_crc", crc_val, 15'h4599);
    cyc(0, 0, 0, 0, 0, 1);

    for (int f = 0; f < 40; f++) begin
      bit tx;
      int ep;
      tx = 1'($urandom_range(0, 1));
      ep = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0) begin
        cyc(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        repeat ($urandom_range(1, 4)) cyc(0, 0, 1, 1'($urandom_range(0, 1)), 0, 0);
      end
      msg.delete();
      repeat ($urandom_range(1, 40)) msg.push_back(1'($urandom_range(0, 1)));
      run_frame(tx, tx ? -1 : ep, -1);
      idle($urandom_range(0, 1));
    end
    idle(3);

    msg = '{1};
    run_frame(0, -1, -1);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_crc_val", crc_val, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", crc_done, 0);
    chk("mid_rst_err", crc_err, 0);
    chk("mid_rst_tx_valid", tx_crc_valid, 0);
    chk("mid_rst_tx_bit", tx_crc_bit, 0);
    @(posedge clk);
    #1 rst = 0;
    idle(3);

    chk("sb_drain", sb_q.size(), 0);
    chk("tx_bits_drain", exp_bits_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
